axi_err_responder: RTL and testbench

AXI_ERR_RESPONDER -- requirements
Module: axi_err_responder

---
 rtl/axi_pkg.sv | 72 +++++++
 rtl/fifo_v3.sv | 53 +++++
 rtl/axi_err_responder.sv | 93 +++++++++
 tb/tb_axi_err_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/ATOP encodings, the ATOP read-response decode helper
// and default request/response channel structs (4-bit id, 64-bit data).
package axi_pkg;
    typedef logic [1:0] resp_t;
    typedef logic [5:0] atop_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
    localparam logic [1:0] ATOMICSTORE = 2'b01;
    localparam logic [1:0] ATOMICLOAD  = 2'b10;
    localparam atop_t ATOMICSWAP = 6'b110000;
    localparam atop_t ATOMICCMP  = 6'b110001;

    // Atomics that return data on R in addition to the B response
    function automatic logic atop_r_resp(input atop_t atop);
        return atop[5:4] == ATOMICLOAD || atop == ATOMICSWAP || atop == ATOMICCMP;
    endfunction

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        atop_t       atop;
    } default_aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } default_w_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } default_ar_t;

    typedef struct packed {
        logic [3:0] id;
        resp_t      resp;
        logic       user;
    } default_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        resp_t       resp;
        logic        last;
        logic        user;
    } default_r_t;

    typedef struct packed {
        default_aw_t aw;
        logic        aw_valid;
        default_w_t  w;
        logic        w_valid;
        logic        b_ready;
        default_ar_t ar;
        logic        ar_valid;
        logic        r_ready;
    } default_req_t;

    typedef struct packed {
        logic       aw_ready;
        logic       w_ready;
        logic       ar_ready;
        logic       b_valid;
        default_b_t b;
        logic       r_valid;
        default_r_t r;
    } default_resp_t;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: common_cells style FIFO with optional fall-through; rst_ni and
// flush_i both clear the pointers synchronously on the rising clock edge.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam logic [ADDR_DEPTH:0]   FullCnt = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);

    dtype mem [DEPTH];
    logic [ADDR_DEPTH-1:0] rd, wr;
    logic [ADDR_DEPTH:0] cnt;
    logic bypass, do_push, do_pop, unused_testmode;

    assign unused_testmode = testmode_i;
    assign bypass  = FALL_THROUGH && cnt == '0 && push_i && pop_i;
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && cnt != '0 && !bypass;
    assign full_o  = cnt == FullCnt;
    assign empty_o = cnt == '0 && !(FALL_THROUGH && push_i);
    assign usage_o = cnt[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && cnt == '0) ? data_i : mem[rd];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr <= (wr == LastPtr) ? '0 : wr + ADDR_DEPTH'(1);
            if (do_pop) rd <= (rd == LastPtr) ? '0 : rd + ADDR_DEPTH'(1);
            cnt <= cnt + (ADDR_DEPTH+1)'(do_push) - (ADDR_DEPTH+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i)
        if (do_push) mem[wr] <= data_i;
endmodule

// File: rtl/axi_err_responder.sv
// axi_err_responder: terminates every AXI transaction with SLVERR.
// AXI_ERR_RESPONDER_ATOP_EN enables R-beat injection for atomics that return data.
module axi_err_responder import axi_pkg::*; #(
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned MaxTxns      = 8,
    parameter logic [63:0] RespData     = 64'hCA11AB1E_BADCAB1E,
    parameter type         axi_req_t    = default_req_t,
    parameter type         axi_resp_t   = default_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);
    localparam int unsigned RqW = AxiIdWidth + 8;
    localparam int unsigned UsW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

    logic aw_full, aw_empty, aw_push, aw_pop, aw_r, aw_r_push;
    logic b_full, b_empty, b_pop;
    logic r_full, r_empty, r_push, r_pop, r_hs, r_last;
    logic aw_ready, w_ready, ar_ready, ar_push, b_valid, r_valid;
    logic [AxiIdWidth-1:0] aw_head, b_head;
    logic [RqW-1:0] r_in, r_head;
    logic [UsW-1:0] aw_usage, b_usage, r_usage;
    logic [7:0] beat;
    logic unused;

`ifdef AXI_ERR_RESPONDER_ATOP_EN
    assign aw_r = atop_r_resp(slv_req_i.aw.atop);
`else
    assign aw_r = 1'b0;
`endif
    assign unused = ^{slv_req_i.aw.addr, slv_req_i.aw.atop, slv_req_i.w.data,
                      slv_req_i.ar.addr, aw_usage, b_usage, r_usage};

    // An atomic needing R beats may only enter when both queues have room
    assign aw_ready  = !rst_i && !aw_full && !(aw_r && r_full);
    assign aw_push   = slv_req_i.aw_valid && aw_ready;
    assign aw_r_push = aw_push && aw_r;
    assign ar_ready  = !rst_i && !r_full && !aw_r_push;
    assign ar_push   = slv_req_i.ar_valid && ar_ready;
    assign r_push    = ar_push || aw_r_push;
    assign r_in      = aw_r_push ? {slv_req_i.aw.id, slv_req_i.aw.len}
                                 : {slv_req_i.ar.id, slv_req_i.ar.len};

    assign w_ready = !rst_i && !aw_empty && !b_full;
    assign aw_pop  = slv_req_i.w_valid && w_ready && slv_req_i.w.last;
    assign b_valid = !rst_i && !b_empty;
    assign b_pop   = b_valid && slv_req_i.b_ready;

    assign r_valid = !rst_i && !r_empty;
    assign r_last  = beat == r_head[7:0];
    assign r_hs    = r_valid && slv_req_i.r_ready;
    assign r_pop   = r_hs && r_last;

    always_ff @(posedge clk_i)
        if (rst_i) beat <= '0;
        else if (r_hs) beat <= r_last ? '0 : beat + 8'd1;

    fifo_v3 #(.DATA_WIDTH(AxiIdWidth), .DEPTH(MaxTxns)) i_aw_fifo (
        .clk_i(clk_i), .rst_ni(!rst_i), .flush_i(1'b0), .testmode_i(1'b0),
        .full_o(aw_full), .empty_o(aw_empty), .usage_o(aw_usage),
        .data_i(slv_req_i.aw.id), .push_i(aw_push), .data_o(aw_head), .pop_i(aw_pop)
    );

    fifo_v3 #(.DATA_WIDTH(AxiIdWidth), .DEPTH(MaxTxns)) i_b_fifo (
        .clk_i(clk_i), .rst_ni(!rst_i), .flush_i(1'b0), .testmode_i(1'b0),
        .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage),
        .data_i(aw_head), .push_i(aw_pop), .data_o(b_head), .pop_i(b_pop)
    );

    fifo_v3 #(.DATA_WIDTH(RqW), .DEPTH(MaxTxns)) i_r_fifo (
        .clk_i(clk_i), .rst_ni(!rst_i), .flush_i(1'b0), .testmode_i(1'b0),
        .full_o(r_full), .empty_o(r_empty), .usage_o(r_usage),
        .data_i(r_in), .push_i(r_push), .data_o(r_head), .pop_i(r_pop)
    );

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.b.id     = b_head;
        slv_resp_o.b.resp   = RESP_SLVERR;
        slv_resp_o.r_valid  = r_valid;
        slv_resp_o.r.id     = r_head[RqW-1:8];
        slv_resp_o.r.data   = AxiDataWidth'(RespData);
        slv_resp_o.r.resp   = RESP_SLVERR;
        slv_resp_o.r.last   = r_last;
    end
endmodule

// File: tb/tb_axi_err_responder.sv
// tb_axi_err_responder: table-driven transactions plus hand sequences for
// queue-full, AW/AR arbitration and mid-burst reset, checked by a B/R scoreboard.
module tb_axi_err_responder;
    import axi_pkg::*;

`ifdef AXI_ERR_RESPONDER_ATOP_EN
    localparam bit ATOP = 1'b1;
`else
    localparam bit ATOP = 1'b0;
`endif
    localparam logic [63:0] RESP_DATA = 64'hCA11AB1E_BADCAB1E;

    typedef struct {
        bit         wr;
        logic [3:0] id;
        logic [7:0] len;
        logic [5:0] atop;
        bit         bp;
        int         exp_r;
    } vec_t;

    typedef struct {
        logic [3:0] id;
        logic       last;
    } rexp_t;

    logic clk, rst, r_rdy, b_rdy;
    bit bp;
    default_req_t req, dut_req;
    default_resp_t rsp;
    logic [3:0] b_exp[$];
    rexp_t r_exp[$];
    int n_cmp = 0, n_err = 0, b_cnt = 0, r_cnt = 0;
    bit r_stall, b_stall;
    default_r_t r_prev;
    default_b_t b_prev;
    vec_t vec[10];

    axi_err_responder #(
        .AxiIdWidth(4), .AxiDataWidth(64), .MaxTxns(8), .RespData(RESP_DATA),
        .axi_req_t(default_req_t), .axi_resp_t(default_resp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst), .slv_req_i(dut_req), .slv_resp_o(rsp)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        dut_req = req;
        dut_req.r_ready = r_rdy;
        dut_req.b_ready = b_rdy;
    end

    initial begin
        r_rdy = 1;
        b_rdy = 1;
        forever begin
            @(posedge clk);
            #1;
            r_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            b_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every B/R handshake is popped against the expected queues
    always @(negedge clk) begin
        if (rst) begin
            r_stall = 0;
            b_stall = 0;
        end else begin
            if (r_stall) begin
                chk("r_hold_valid", rsp.r_valid, 1);
                chk("r_hold_payload", rsp.r, r_prev);
            end
            if (b_stall) begin
                chk("b_hold_valid", rsp.b_valid, 1);
                chk("b_hold_payload", rsp.b, b_prev);
            end
            if (rsp.b_valid && dut_req.b_ready) begin
                b_cnt++;
                if (b_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b_unexpected: got id %0h required none", rsp.b.id);
                end else begin
                    chk("b_id", rsp.b.id, b_exp[0]);
                    chk("b_resp", rsp.b.resp, 2'b10);
                    chk("b_user", rsp.b.user, 0);
                    void'(b_exp.pop_front());
                end
            end
            if (rsp.r_valid && dut_req.r_ready) begin
                r_cnt++;
                if (r_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL r_unexpected: got id %0h required none", rsp.r.id);
                end else begin
                    chk("r_id", rsp.r.id, r_exp[0].id);
                    chk("r_last", rsp.r.last, r_exp[0].last);
                    chk("r_data", rsp.r.data, RESP_DATA);
                    chk("r_resp", rsp.r.resp, 2'b10);
                    chk("r_user", rsp.r.user, 0);
                    void'(r_exp.pop_front());
                end
            end
            r_stall = rsp.r_valid && !dut_req.r_ready;
            b_stall = rsp.b_valid && !dut_req.b_ready;
            r_prev = rsp.r;
            b_prev = rsp.b;
        end
    end

    task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [5:0] atop);
        int t = 0;
        req.aw.id = id;
        req.aw.len = len;
        req.aw.atop = atop;
        req.aw.addr = 32'h1000;
        req.aw_valid = 1;
        @(negedge clk);
        while (!rsp.aw_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("aw_accept", rsp.aw_ready, 1);
        @(posedge clk);
        #1 req.aw_valid = 0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [7:0] len);
        int t = 0;
        req.ar.id = id;
        req.ar.len = len;
        req.ar.addr = 32'h2000;
        req.ar_valid = 1;
        @(negedge clk);
        while (!rsp.ar_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ar_accept", rsp.ar_ready, 1);
        @(posedge clk);
        #1 req.ar_valid = 0;
    endtask

    task automatic send_w(input int n, input bit chk_b);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            req.w.data = {$urandom, $urandom};
            req.w.last = (k == n - 1);
            req.w_valid = 1;
            @(negedge clk);
            while (!rsp.w_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("w_accept", rsp.w_ready, 1);
            if (chk_b && k == n - 1) chk("b_before_last", rsp.b_valid, 0);
            @(posedge clk);
            #1;
        end
        req.w_valid = 0;
        req.w.last = 0;
        if (chk_b) begin
            @(negedge clk);
            chk("b_after_last", rsp.b_valid, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((b_exp.size() != 0 || r_exp.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (b_exp.size() != 0 || r_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: b left %0d r left %0d required 0 0", b_exp.size(), r_exp.size());
            b_exp.delete();
            r_exp.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        req = '0;
        rst = 1;
        bp = 0;
        vec[0] = '{1, 4'd3,  8'd3,   6'b000000, 0, 0};
        vec[1] = '{0, 4'd5,  8'd7,   6'b000000, 0, 8};
        vec[2] = '{1, 4'd2,  8'd0,   6'b100000, 0, ATOP ? 1 : 0};
        vec[3] = '{1, 4'd7,  8'd1,   6'b110000, 0, ATOP ? 2 : 0};
        vec[4] = '{1, 4'd9,  8'd0,   6'b010000, 0, 0};
        vec[5] = '{0, 4'd15, 8'd0,   6'b000000, 0, 1};
        vec[6] = '{0, 4'd1,  8'd15,  6'b000000, 1, 16};
        vec[7] = '{1, 4'd0,  8'd7,   6'b000000, 1, 0};
        vec[8] = '{1, 4'd12, 8'd2,   6'b110001, 1, ATOP ? 3 : 0};
        vec[9] = '{0, 4'd11, 8'd255, 6'b000000, 0, 256};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_aw_ready", rsp.aw_ready, 0);
        chk("rst_w_ready", rsp.w_ready, 0);
        chk("rst_ar_ready", rsp.ar_ready, 0);
        chk("rst_b_valid", rsp.b_valid, 0);
        chk("rst_r_valid", rsp.r_valid, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("idle_aw_ready", rsp.aw_ready, 1);
        chk("idle_ar_ready", rsp.ar_ready, 1);
        chk("idle_w_ready", rsp.w_ready, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            bp = vec[i].bp;
            b_cnt = 0;
            r_cnt = 0;
            if (vec[i].wr) b_exp.push_back(vec[i].id);
            for (int k = 0; k < vec[i].exp_r; k++) r_exp.push_back('{vec[i].id, k == vec[i].exp_r - 1});
            if (vec[i].wr) begin
                send_aw(vec[i].id, vec[i].len, vec[i].atop);
                send_w(int'(vec[i].len) + 1, 1);
            end else begin
                send_ar(vec[i].id, vec[i].len);
            end
            wait_drain();
            chk("vec_b_count", b_cnt, vec[i].wr ? 1 : 0);
            chk("vec_r_count", r_cnt, vec[i].exp_r);
        end
        bp = 0;
        @(posedge clk);
        #1;

        // Fill the AW queue, then let a W burst reopen it for the ninth AW
        b_cnt = 0;
        for (int i = 0; i < 9; i++) b_exp.push_back(4'(i));
        for (int i = 0; i < 8; i++) send_aw(4'(i), 8'd0, 6'b0);
        req.aw.id = 4'd8;
        req.aw.len = 8'd0;
        req.aw.atop = 6'b0;
        req.aw_valid = 1;
        @(negedge clk);
        chk("full_aw_ready", rsp.aw_ready, 0);
        chk("full_w_ready", rsp.w_ready, 1);
        @(posedge clk);
        #1;
        send_w(1, 0);
        @(negedge clk);
        chk("reopen_aw_ready", rsp.aw_ready, 1);
        @(posedge clk);
        #1 req.aw_valid = 0;
        for (int i = 0; i < 8; i++) send_w(1, 0);
        wait_drain();
        chk("full_b_count", b_cnt, 9);

        // Atomic AW and AR in the same cycle
        b_cnt = 0;
        r_cnt = 0;
        b_exp.push_back(4'd4);
        if (ATOP) begin
            r_exp.push_back('{4'd4, 1'b0});
            r_exp.push_back('{4'd4, 1'b1});
        end
        for (int k = 0; k < 3; k++) r_exp.push_back('{4'd6, k == 2});
        req.aw.id = 4'd4;
        req.aw.len = 8'd1;
        req.aw.atop = 6'b100000;
        req.aw_valid = 1;
        req.ar.id = 4'd6;
        req.ar.len = 8'd2;
        req.ar_valid = 1;
        @(negedge clk);
        chk("arb_aw_ready", rsp.aw_ready, 1);
        chk("arb_ar_ready", rsp.ar_ready, !ATOP);
        @(posedge clk);
        #1;
        req.aw_valid = 0;
        req.ar_valid = ATOP;
        @(negedge clk);
        chk("arb_ar_ready_next", rsp.ar_ready, 1);
        @(posedge clk);
        #1 req.ar_valid = 0;
        send_w(2, 1);
        wait_drain();
        chk("arb_r_count", r_cnt, ATOP ? 5 : 3);

        // Reset pulse in the middle of a 256-beat read burst
        r_cnt = 0;
        for (int k = 0; k < 256; k++) r_exp.push_back('{4'd10, k == 255});
        send_ar(4'd10, 8'd255);
        t = 0;
        while (r_cnt < 100 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk("mid_reached_beat100", r_cnt, 100);
        #1 rst = 1;
        @(negedge clk);
        chk("mid_rst_r_valid", rsp.r_valid, 0);
        chk("mid_rst_aw_ready", rsp.aw_ready, 0);
        r_exp.delete();
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("post_rst_aw_ready", rsp.aw_ready, 1);
        chk("post_rst_ar_ready", rsp.ar_ready, 1);
        chk("post_rst_r_valid", rsp.r_valid, 0);
        chk("post_rst_b_valid", rsp.b_valid, 0);
        repeat (20) @(posedge clk);
        chk("post_rst_no_beats", r_cnt, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
